pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed-width single-cycle CLA adder.
- Splits a WIDTH-bit operation into NGROUPS = WIDTH/GROUP lookahead groups, one group per pipeline stage; the carry is registered between stages.
- Valid/ready handshakes on input and output, full throughput (one op/cycle), backpressure-safe.
- Sits in the datapath library as the timing-closed adder for wide operands.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of GROUP (elaboration error otherwise).
- GROUP, 4, bits per lookahead group (>=1); NGROUPS = WIDTH/GROUP = pipeline depth.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- io_in_valid  in  1  operands present.
- io_in_ready  out  1  stage 0 can accept.
- io_a  in  WIDTH  operand A.
- io_b  in  WIDTH  operand B.
- io_c_in  in  1  carry-in (add) / borrow-in (sub).
- io_sub  in  1  1 = subtract (A - B - borrow).
- io_out_valid  out  1  result present.
- io_out_ready  in  1  consumer accepts.
- io_s  out  WIDTH  sum/difference.
- io_c_out  out  1  raw carry out of MSB.
- io_ovf  out  1  signed overflow.
- io_pg  out  1  word-level propagate.
- io_gg  out  1  word-level generate.

Behaviour:
- Reset: reset low at a rising edge clears every stage valid bit. io_out_valid=0 from the next cycle. io_s, io_c_out, io_ovf, io_pg, io_gg = 0 while reset is held. Reset mid-operation discards all in-flight ops; no stale output after release.
- Operand conditioning at acceptance:
  - b_eff = io_sub ? ~io_b : io_b.
  - cin_eff = io_sub ? ~io_c_in : io_c_in.
- Per bit: p_i = a_i | b_eff_i; g_i = a_i & b_eff_i; s_i = a_i ^ b_eff_i ^ c_i.
- Within a group: carries by lookahead, c_{i+1} = g_i | (p_i & c_i), flattened, with no ripple through adder instances. Group PG = AND of p; group GG by standard lookahead combine.
- Stage k (0..NGROUPS-1) combinationally computes group k from its input register data (stage 0 from the ports) and loads into register k:
  - group-k sum bits
  - carry out of group k
  - running word PG/GG
  - remaining upper operand bits, plus sum bits already computed.
- Stage registers carry the mode-independent b_eff; io_sub is not needed past acceptance.
- Handshake:
  - Accept when io_in_valid & io_in_ready.
  - ready_k = !valid_k | ready_{k+1}; ready_NGROUPS = io_out_ready; io_in_ready = ready_0.
  - A stalled stage holds its data unchanged.
  - Output fields are stable while io_out_valid=1 and io_out_ready=0.
- Latency: op accepted in cycle t gives io_out_valid=1 in cycle t+NGROUPS with no stall. Throughput is 1 op/cycle. Order is preserved; no drop, no duplicate.
- Simultaneous events:
  - A full pipeline with io_out_ready=1 accepts a new op in the same cycle the last one leaves.
  - With all stages full and io_out_ready=0, io_in_ready=0.
- Outputs:
  - io_c_out is the raw MSB carry; in sub mode, 1 = no borrow.
  - io_ovf = carry into MSB XOR carry out of MSB.
  - io_pg = AND of all p_i; io_gg = word-level generate, independent of cin.
- Widths: no truncation except carry-out beyond MSB, which is reported in io_c_out.
- Degenerate case GROUP=WIDTH: single stage, latency 1.

Test Plan (WIDTH=16, GROUP=4, latency 4):
- Add 0xFFFF+0x0001, c_in=0, accepted cycle 0 -> cycle 4: io_out_valid=1, s=0x0000, c_out=1, ovf=0, pg=1, gg=1.
- Add 0x7FFF+0x0001, c_in=0 -> s=0x8000, c_out=0, ovf=1; add 0x1234+0x4321, c_in=1 -> s=0x5556, c_out=0, ovf=0.
- Sub 0x0005-0x0007, borrow 0 -> s=0xFFFE, c_out=0, ovf=0; sub 0x8000-0x0001, borrow 0 -> s=0x7FFF, c_out=1, ovf=1.
- Stream of 8 random ops back-to-back, io_out_ready=1 -> results in cycles 4..11 consecutively, in order, each matching a reference model.
- Continuous input, io_out_ready=0 in cycles 5..10:
  - io_in_ready drops once 4 ops are resident; the head result holds stable.
  - After release, all ops emerge in order with none lost or duplicated.
- Reset low for 1 cycle with 3 ops in flight -> io_out_valid=0 next cycle; no result appears afterwards until a new op is accepted, which appears 4 cycles after acceptance.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: WIDTH-bit add/sub, one GROUP-bit lookahead group per pipeline stage
// Ports: clock/reset (sync, active-low); io_in_valid/io_in_ready + io_a/io_b/io_c_in/io_sub in;
//        io_out_valid/io_out_ready + io_s/io_c_out/io_ovf/io_pg/io_gg out.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic             io_c_in,
  input  logic             io_sub,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_s,
  output logic             io_c_out,
  output logic             io_ovf,
  output logic             io_pg,
  output logic             io_gg
);
  localparam int NGROUPS = WIDTH / ((GROUP < 1) ? 1 : GROUP);
  if (GROUP < 1 || WIDTH % GROUP != 0) begin : g_bad_width
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of GROUP");
  end
  logic [NGROUPS-1:0] v_q, v_d, c_q, c_d, cm_q, cm_d, pg_q, pg_d, gg_q, gg_d;
  logic [NGROUPS-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [NGROUPS:0] rdy;
  always_comb begin
    rdy[NGROUPS] = io_out_ready;
    for (int k = NGROUPS - 1; k >= 0; k--) rdy[k] = !v_q[k] | rdy[k+1];
  end
  // Stage k consumes register k-1 (ports for k=0) and fills register k.
  // gc/pc accumulate the group generate/propagate up to the current bit, so
  // every carry is a flat function of the group carry-in c_i.
  always_comb begin
    logic [WIDTH-1:0] a_i, b_i, s;
    logic c_i, pg_i, gg_i, v_i, p, g, gc, pc, c, cm;
    int src, idx;
    v_d = '0; c_d = '0; cm_d = '0; pg_d = '0; gg_d = '0;
    a_d = '0; b_d = '0; s_d = '0;
    for (int k = 0; k < NGROUPS; k++) begin
      src = (k > 0) ? k - 1 : 0;
      a_i = (k == 0) ? io_a : a_q[src];
      b_i = (k == 0) ? (io_sub ? ~io_b : io_b) : b_q[src];
      s = (k == 0) ? '0 : s_q[src];
      c_i = (k == 0) ? (io_sub ^ io_c_in) : c_q[src];
      pg_i = (k == 0) ? 1'b1 : pg_q[src];
      gg_i = (k == 0) ? 1'b0 : gg_q[src];
      v_i = (k == 0) ? io_in_valid : v_q[src];
      gc = 1'b0;
      pc = 1'b1;
      c = c_i;
      cm = 1'b0;
      for (int j = 0; j < GROUP; j++) begin
        idx = k * GROUP + j;
        p = a_i[idx] | b_i[idx];
        g = a_i[idx] & b_i[idx];
        s[idx] = a_i[idx] ^ b_i[idx] ^ c;
        if (j == GROUP - 1) cm = c;
        gc = g | (p & gc);
        pc = pc & p;
        c = gc | (pc & c_i);
      end
      v_d[k] = v_i;
      a_d[k] = a_i;
      b_d[k] = b_i;
      s_d[k] = s;
      c_d[k] = c;
      cm_d[k] = cm;
      pg_d[k] = pg_i & pc;
      gg_d[k] = gc | (pc & gg_i);
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      v_q <= '0;
      c_q <= '0;
      cm_q <= '0;
      pg_q <= '0;
      gg_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
    end else begin
      for (int k = 0; k < NGROUPS; k++) begin
        if (rdy[k]) begin
          v_q[k] <= v_d[k];
          c_q[k] <= c_d[k];
          cm_q[k] <= cm_d[k];
          pg_q[k] <= pg_d[k];
          gg_q[k] <= gg_d[k];
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          s_q[k] <= s_d[k];
        end
      end
    end
  end
  // Operand copies leaving the last stage and the MSB carry-in of earlier stages are dead.
  logic unused_tail;
  assign unused_tail = ^{a_q, b_q, cm_q};
  assign io_in_ready = rdy[0];
  assign io_out_valid = v_q[NGROUPS-1];
  assign io_s = s_q[NGROUPS-1];
  assign io_c_out = c_q[NGROUPS-1];
  assign io_ovf = cm_q[NGROUPS-1] ^ c_q[NGROUPS-1];
  assign io_pg = pg_q[NGROUPS-1];
  assign io_gg = gg_q[NGROUPS-1];
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: directed bench for the 16-bit, 4-stage pipelined CLA adder
module tb_pipelined_cla_adder;
  typedef struct packed {
    logic [15:0] s;
    logic c;
    logic ovf;
    logic pg;
    logic gg;
  } res_t;
  logic clock = 1'b0;
  logic reset;
  logic io_in_valid, io_in_ready, io_c_in, io_sub;
  logic io_out_valid, io_out_ready, io_c_out, io_ovf, io_pg, io_gg;
  logic [15:0] io_a, io_b, io_s;
  int checks = 0;
  int errors = 0;
  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_a(io_a), .io_b(io_b), .io_c_in(io_c_in), .io_sub(io_sub),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_s(io_s), .io_c_out(io_c_out), .io_ovf(io_ovf), .io_pg(io_pg), .io_gg(io_gg)
  );
  always #5 clock = ~clock;
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    logic [15:0] be;
    logic [16:0] full, gen;
    res_t r;
    be = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, be} + {16'd0, sub ^ cin};
    gen = {1'b0, a} + {1'b0, be};
    r.s = full[15:0];
    r.c = full[16];
    r.ovf = (a[15] == be[15]) && (full[15] != a[15]);
    r.pg = &(a | be);
    r.gg = gen[16];
    return r;
  endfunction
  function automatic res_t observed();
    return {io_s, io_c_out, io_ovf, io_pg, io_gg};
  endfunction
  task automatic idle();
    io_in_valid = 1'b0;
    io_a = '0;
    io_b = '0;
    io_c_in = 1'b0;
    io_sub = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    io_out_ready = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (io_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", io_out_valid); end
    checks++;
    if (observed() !== res_t'(0)) begin errors++; $display("FAIL reset_outputs got %h want 0", observed()); end
    checks++;
    if (io_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", io_in_ready); end
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask
  task automatic test_directed();
    logic [15:0] ta[5] = '{16'hFFFF, 16'h7FFF, 16'h1234, 16'h0005, 16'h8000};
    logic [15:0] tb[5] = '{16'h0001, 16'h0001, 16'h4321, 16'h0007, 16'h0001};
    logic tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic tsub[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    res_t te[5] = '{
      '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b1},
      '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b0},
      '{16'h5556, 1'b0, 1'b0, 1'b0, 1'b0},
      '{16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0},
      '{16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1}
    };
    for (int i = 0; i < 5; i++) begin
      io_in_valid = 1'b1;
      io_a = ta[i];
      io_b = tb[i];
      io_c_in = tc[i];
      io_sub = tsub[i];
      #1;
      checks++;
      if (io_in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got %b want 1", i, io_in_ready); end
      for (int e = 0; e < 3; e++) begin
        @(posedge clock);
        #1;
        idle();
        checks++;
        if (io_out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid edge %0d got %b want 0", i, e, io_out_valid); end
      end
      @(posedge clock);
      #1;
      checks++;
      if (io_out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid got %b want 1", i, io_out_valid); end
      checks++;
      if (observed() !== te[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, observed(), te[i]); end
    end
    @(posedge clock);
    #1;
  endtask
  task automatic test_back_to_back();
    logic [15:0] ta[8] = '{16'hA5A5, 16'h0000, 16'hFFFF, 16'h8000, 16'h1357, 16'hF0F0, 16'h7FFF, 16'h4000};
    logic [15:0] tb[8] = '{16'h5A5A, 16'h0000, 16'hFFFF, 16'h8000, 16'h2468, 16'h0F0F, 16'h8000, 16'hC000};
    logic tc[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic tsub[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int t = 0; t <= 10; t++) begin
      if (t < 8) begin
        io_in_valid = 1'b1;
        io_a = ta[t];
        io_b = tb[t];
        io_c_in = tc[t];
        io_sub = tsub[t];
        #1;
        checks++;
        if (io_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", t, io_in_ready); end
      end else idle();
      @(posedge clock);
      #1;
      if (t >= 3) begin
        checks++;
        if (io_out_valid !== 1'b1 || observed() !== model(ta[t-3], tb[t-3], tc[t-3], tsub[t-3])) begin
          errors++;
          $display("FAIL b2b_result op %0d got v=%b %h want v=1 %h", t - 3, io_out_valid, observed(),
                   model(ta[t-3], tb[t-3], tc[t-3], tsub[t-3]));
        end
      end
    end
    idle();
    @(posedge clock);
    #1;
    checks++;
    if (io_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", io_out_valid); end
  endtask
  task automatic test_backpressure();
    logic [15:0] ta[10] = '{16'h0001, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'hFFF0, 16'h8001, 16'h1111, 16'hABCD, 16'h0F00};
    logic [15:0] tb[10] = '{16'h0001, 16'h0203, 16'h0405, 16'h0607, 16'h0809, 16'h0011, 16'h0002, 16'h2222, 16'h1234, 16'h00FF};
    logic tsub[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int nxt = 0;
    int got = 0;
    int cyc = 0;
    logic acc;
    while (got < 10 && cyc < 60) begin
      io_out_ready = !(cyc >= 5 && cyc <= 10);
      io_in_valid = (nxt < 10);
      io_a = ta[nxt % 10];
      io_b = tb[nxt % 10];
      io_sub = tsub[nxt % 10];
      io_c_in = nxt[0];
      #1;
      acc = io_in_valid && io_in_ready;
      if (cyc >= 5 && cyc <= 10) begin
        checks++;
        if (io_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b want 0", cyc, io_in_ready); end
        checks++;
        if (io_out_valid !== 1'b1 || got != 1 || observed() !== model(ta[1], tb[1], 1'b1, tsub[1])) begin
          errors++;
          $display("FAIL bp_head_hold cycle %0d got v=%b %h idx %0d want v=1 %h idx 1", cyc, io_out_valid, observed(), got,
                   model(ta[1], tb[1], 1'b1, tsub[1]));
        end
      end
      if (io_out_valid && io_out_ready) begin
        checks++;
        if (observed() !== model(ta[got], tb[got], got[0], tsub[got])) begin
          errors++;
          $display("FAIL bp_result op %0d got %h want %h", got, observed(), model(ta[got], tb[got], got[0], tsub[got]));
        end
        got++;
      end
      @(posedge clock);
      #1;
      if (acc) nxt++;
      cyc++;
    end
    checks++;
    if (got != 10 || nxt != 10) begin errors++; $display("FAIL bp_count got %0d out %0d in want 10 10", got, nxt); end
    idle();
    io_out_ready = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (io_out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate got %b want 0", io_out_valid); end
  endtask
  task automatic test_reset_midflight();
    for (int i = 0; i < 3; i++) begin
      io_in_valid = 1'b1;
      io_a = 16'h1000 * 16'(i + 1);
      io_b = 16'h0001;
      io_c_in = 1'b0;
      io_sub = 1'b0;
      @(posedge clock);
      #1;
    end
    idle();
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    checks++;
    if (io_out_valid !== 1'b0 || observed() !== res_t'(0)) begin
      errors++;
      $display("FAIL midrst_clear got v=%b %h want v=0 0", io_out_valid, observed());
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (io_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale cycle %0d got %b want 0", i, io_out_valid); end
    end
    io_in_valid = 1'b1;
    io_a = 16'h00FF;
    io_b = 16'h0001;
    io_c_in = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge clock);
      #1;
      idle();
      checks++;
      if (io_out_valid !== (e == 3)) begin errors++; $display("FAIL midrst_latency edge %0d got %b want %b", e, io_out_valid, e == 3); end
    end
    checks++;
    if (io_s !== 16'h0101) begin errors++; $display("FAIL midrst_result got %h want 0101", io_s); end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
